lfsr_8bit_checker: RTL

- Receive-side checker for the 8-bit PRBS test pattern (polynomial x^8+x^6+x^5+x^4+1, reset seed 0xFF).
- Consumes bytes from the UART receive path, self-synchronises to the sequence, then counts matching and mismatching bytes.
- Lets the UART bench or board self-test confirm an error-free link without a reference copy of the transmitted data.

---
 rtl/lfsr_8bit_checker_if.sv | 24 ++
 rtl/lfsr_8bit_checker.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/lfsr_8bit_checker_if.sv
// Byte stream and result bus of the PRBS-8 receive checker.
// master drives bytes (UART receive side / bench); slave is the checker.
interface lfsr_8bit_checker_if #(
  parameter int ERR_W = 16,
  parameter int CNT_W = 32
);
  logic [7:0]       data_in;
  logic             data_valid;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] byte_count;

  modport master (
    output data_in, data_valid, clear,
    input  locked, err_pulse, err_count, byte_count
  );

  modport slave (
    input  data_in, data_valid, clear,
    output locked, err_pulse, err_count, byte_count
  );
endinterface

// File: rtl/lfsr_8bit_checker.sv
// Self-synchronising checker for the x^8+x^6+x^5+x^4+1 PRBS byte stream.
// Optional feature macro LFSR_CHK_AUTO_RELOCK_EN: drop lock after LOSS_COUNT consecutive misses.
module lfsr_8bit_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 8,
  parameter int ERR_W      = 16,
  parameter int CNT_W      = 32
) (
  input logic               clk,
  input logic               rst,
  lfsr_8bit_checker_if.slave bus
);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_COUNT);

  if (LOCK_COUNT < 1 || LOCK_COUNT > 15 || LOSS_COUNT < 1 || LOSS_COUNT > 15) begin : g_bad_params
    $error("lfsr_8bit_checker: LOCK_COUNT and LOSS_COUNT must lie in 1..15");
  end

  // Each byte is the whole generator state, so one byte fully predicts the next.
  function automatic logic [7:0] prbs_next(input logic [7:0] b);
    return {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [7:0]       expected_q, expected_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;
  logic             is_match;

`ifdef LFSR_CHK_AUTO_RELOCK_EN
  localparam logic [3:0] LOSS_LIM = 4'(LOSS_COUNT);
  logic [3:0] miss_cnt_q, miss_cnt_d;
`endif

  assign is_match = (bus.data_in == expected_q);

  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    match_cnt_d  = match_cnt_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    byte_count_d = byte_count_q;
`ifdef LFSR_CHK_AUTO_RELOCK_EN
    miss_cnt_d   = miss_cnt_q;
`endif
    if (bus.data_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (bus.data_in != 8'h00) begin
            expected_d  = prbs_next(bus.data_in);
            match_cnt_d = 4'd0;
            state_d     = ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (is_match) begin
            expected_d  = prbs_next(bus.data_in);
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_q + 4'd1 == LOCK_LIM) begin
              state_d = ST_LOCKED;
`ifdef LFSR_CHK_AUTO_RELOCK_EN
              miss_cnt_d = 4'd0;
`endif
            end
          end else begin
            match_cnt_d = 4'd0;
            if (bus.data_in != 8'h00) expected_d = prbs_next(bus.data_in);
            else                      state_d    = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          // Once locked the local generator free-runs; bad bytes never reseed it.
          expected_d = prbs_next(expected_q);
          if (byte_count_q != {CNT_W{1'b1}}) byte_count_d = byte_count_q + CNT_W'(1);
          if (!is_match) begin
            err_pulse_d = 1'b1;
            if (err_count_q != {ERR_W{1'b1}}) err_count_d = err_count_q + ERR_W'(1);
          end
`ifdef LFSR_CHK_AUTO_RELOCK_EN
          if (is_match) begin
            miss_cnt_d = 4'd0;
          end else if (miss_cnt_q + 4'd1 == LOSS_LIM) begin
            miss_cnt_d = 4'd0;
            state_d    = ST_HUNT;
          end else begin
            miss_cnt_d = miss_cnt_q + 4'd1;
          end
`endif
        end
        default: state_d = ST_HUNT;
      endcase
    end
    if (bus.clear) begin
      err_count_d  = '0;
      byte_count_d = '0;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      expected_q   <= 8'hFF;
      match_cnt_q  <= 4'd0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      byte_count_q <= '0;
`ifdef LFSR_CHK_AUTO_RELOCK_EN
      miss_cnt_q   <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      match_cnt_q  <= match_cnt_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      byte_count_q <= byte_count_d;
`ifdef LFSR_CHK_AUTO_RELOCK_EN
      miss_cnt_q   <= miss_cnt_d;
`endif
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_count  = err_count_q;
  assign bus.byte_count = byte_count_q;

endmodule
